exec_mem_seq: RTL and testbench

- Parametrised memory-access sequencer between the exec stage and the external Wishbone-style bus.
- Exec presents one request (address, data, direction, mem/io, byte/word) and holds it until mem_rdy. The block runs one or two bus cycles, splitting an odd-address word access into two byte cycles.
- It returns assembled read data.
- A configurable ack timeout aborts a hung bus cycle so exec is never blocked forever.

---
 rtl/exec_mem_seq.sv | 195 +++++++++++++++++++
 tb/tb_exec_mem_seq.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_seq.sv
// exec_mem_seq: exec-to-bus memory access sequencer.
// Splits odd word accesses into two byte cycles; aborts hung cycles.
module exec_mem_seq #(
   parameter int ADDR_W          = 20,
   parameter int TIMEOUT         = 255,
   parameter int SPLIT_UNALIGNED = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   input  logic [15:0]       wr_data,
   input  logic              we,
   input  logic              m_io,
   input  logic              byteop,
   output logic              mem_rdy,
   output logic [15:0]       memout,
   output logic              busy,
   output logic              bus_err,
   output logic              bus_cyc,
   output logic              bus_stb,
   output logic              bus_we,
   output logic              bus_tga,
   output logic [ADDR_W-2:0] bus_adr,
   output logic [1:0]        bus_sel,
   output logic [15:0]       bus_dat_o,
   input  logic [15:0]       bus_dat_i,
   input  logic              bus_ack
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, CYC1, CYC2, DONE} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [7:0]       hi_byte, hi_byte_n;
   logic             split, split_n;
   logic             bytes, bytes_n;
   logic             lane_hi, lane_hi_n;

   logic              mem_rdy_n, busy_n, err_n;
   logic [15:0]       memout_n;
   logic              cyc_n, stb_n, we_n, tga_n;
   logic [ADDR_W-2:0] adr_n;
   logic [1:0]        sel_n;
   logic [15:0]       dat_n;

   logic odd_split;
   logic tmo;

   assign odd_split = (SPLIT_UNALIGNED != 0) && !byteop && addr[0];
   // Last tolerated cycle without ack; an ack here still wins.
   assign tmo = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

   // Next state and next registered outputs.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      hi_byte_n = hi_byte;
      split_n   = split;
      bytes_n   = bytes;
      lane_hi_n = lane_hi;
      mem_rdy_n = 1'b0;
      err_n     = 1'b0;
      memout_n  = memout;
      cyc_n     = bus_cyc;
      stb_n     = bus_stb;
      we_n      = bus_we;
      tga_n     = bus_tga;
      adr_n     = bus_adr;
      sel_n     = bus_sel;
      dat_n     = bus_dat_o;
      busy_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               state_n   = CYC1;
               cnt_n     = '0;
               split_n   = odd_split;
               bytes_n   = byteop;
               lane_hi_n = addr[0];
               hi_byte_n = wr_data[15:8];
               cyc_n     = 1'b1;
               stb_n     = 1'b1;
               we_n      = we;
               tga_n     = m_io;
               adr_n     = addr[ADDR_W-1:1];
               unique case (1'b1)
                  byteop && addr[0]: begin
                     sel_n = 2'b10;
                     dat_n = {wr_data[7:0], 8'h00};
                  end
                  byteop && !addr[0]: begin
                     sel_n = 2'b01;
                     dat_n = {8'h00, wr_data[7:0]};
                  end
                  odd_split: begin
                     sel_n = 2'b10;
                     dat_n = {wr_data[7:0], 8'h00};
                  end
                  default: begin
                     sel_n = 2'b11;
                     dat_n = wr_data;
                  end
               endcase
            end
         end
         CYC1, CYC2: begin
            if (bus_ack) begin
               if (state == CYC1 && split) begin
                  state_n  = CYC2;
                  cnt_n    = '0;
                  memout_n = {memout[15:8], bus_dat_i[15:8]};
                  adr_n    = bus_adr + 1'b1;
                  sel_n    = 2'b01;
                  dat_n    = {8'h00, hi_byte};
               end else begin
                  state_n = DONE;
                  if (bus_we)
                     memout_n = 16'h0000;
                  else if (state == CYC2)
                     memout_n = {bus_dat_i[7:0], memout[7:0]};
                  else if (bytes)
                     memout_n = {8'h00, lane_hi ? bus_dat_i[15:8]
                                                : bus_dat_i[7:0]};
                  else
                     memout_n = bus_dat_i;
               end
            end else if (tmo) begin
               state_n  = DONE;
               err_n    = 1'b1;
               memout_n = 16'hFFFF;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DONE: state_n = IDLE;
      endcase
      // Entering DONE releases the bus and signals completion.
      if (state_n == DONE && state != DONE) begin
         cyc_n     = 1'b0;
         stb_n     = 1'b0;
         we_n      = 1'b0;
         tga_n     = 1'b0;
         adr_n     = '0;
         sel_n     = 2'b00;
         dat_n     = 16'h0000;
         mem_rdy_n = 1'b1;
      end
      busy_n = (state_n != IDLE);
   end

   // State, counter, latched request fields and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         hi_byte   <= 8'h00;
         split     <= 1'b0;
         bytes     <= 1'b0;
         lane_hi   <= 1'b0;
         mem_rdy   <= 1'b0;
         memout    <= 16'h0000;
         busy      <= 1'b0;
         bus_err   <= 1'b0;
         bus_cyc   <= 1'b0;
         bus_stb   <= 1'b0;
         bus_we    <= 1'b0;
         bus_tga   <= 1'b0;
         bus_adr   <= '0;
         bus_sel   <= 2'b00;
         bus_dat_o <= 16'h0000;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         hi_byte   <= hi_byte_n;
         split     <= split_n;
         bytes     <= bytes_n;
         lane_hi   <= lane_hi_n;
         mem_rdy   <= mem_rdy_n;
         memout    <= memout_n;
         busy      <= busy_n;
         bus_err   <= err_n;
         bus_cyc   <= cyc_n;
         bus_stb   <= stb_n;
         bus_we    <= we_n;
         bus_tga   <= tga_n;
         bus_adr   <= adr_n;
         bus_sel   <= sel_n;
         bus_dat_o <= dat_n;
      end
   end

endmodule

// File: tb/tb_exec_mem_seq.sv
// tb_exec_mem_seq: randomized bench for exec_mem_seq.
// A per-cycle timeline model drives the bus and predicts every output.
module tb_exec_mem_seq;

   localparam int AW  = 20;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic [AW-1:0] addr;
   logic [15:0]   wr_data;
   logic          we;
   logic          m_io;
   logic          byteop;
   logic          mem_rdy;
   logic [15:0]   memout;
   logic          busy;
   logic          bus_err;
   logic          bus_cyc;
   logic          bus_stb;
   logic          bus_we;
   logic          bus_tga;
   logic [AW-2:0] bus_adr;
   logic [1:0]    bus_sel;
   logic [15:0]   bus_dat_o;
   logic [15:0]   bus_dat_i;
   logic          bus_ack;

   int n_tests = 0;
   int n_fail  = 0;

   exec_mem_seq #(
      .ADDR_W(AW),
      .TIMEOUT(TMO),
      .SPLIT_UNALIGNED(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .addr(addr),
      .wr_data(wr_data),
      .we(we),
      .m_io(m_io),
      .byteop(byteop),
      .mem_rdy(mem_rdy),
      .memout(memout),
      .busy(busy),
      .bus_err(bus_err),
      .bus_cyc(bus_cyc),
      .bus_stb(bus_stb),
      .bus_we(bus_we),
      .bus_tga(bus_tga),
      .bus_adr(bus_adr),
      .bus_sel(bus_sel),
      .bus_dat_o(bus_dat_o),
      .bus_dat_i(bus_dat_i),
      .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   // One clock cycle of stimulus plus the outputs expected during it.
   typedef struct {
      bit            rst_n;
      bit            req;
      logic [AW-1:0] addr;
      logic [15:0]   wd;
      bit            we;
      bit            io;
      bit            bt;
      bit            ack;
      logic [15:0]   di;
      bit            cyc;
      logic [AW-2:0] adr;
      logic [1:0]    sel;
      logic [15:0]   dat;
      bit            rdy;
      bit            err;
      logic [15:0]   mem;
      bit            chk_mem;
      bit            busy;
      int            idx;
   } step_t;

   step_t q[$];
   step_t exp;
   bit    exp_on = 1'b0;

   logic [AW-2:0] o_adr[$];
   logic [1:0]    o_sel[$];
   logic [15:0]   o_dat[$];
   logic [15:0]   o_mem;
   logic          o_err;
   int            o_lat;
   int            o_rdy;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] e);
      n_tests++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, e, $time);
      end
   endtask

   function automatic step_t base(bit r, logic [AW-1:0] a, logic [15:0] wd,
                                  bit w, bit io, bit bt);
      step_t s;
      s = '{default: 0};
      s.rst_n = 1'b1;
      s.req   = r;
      s.addr  = a;
      s.wd    = wd;
      s.we    = w;
      s.io    = io;
      s.bt    = bt;
      s.di    = 16'($urandom);
      return s;
   endfunction

   // Timeline of one request: idle cycle with req, bus beats, done cycle.
   task automatic build(input logic [AW-1:0] a, input logic [15:0] wd,
                        input bit w, input bit io, input bit bt,
                        input int w0, input int w1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input bit drop);
      step_t         s;
      int            nb, n, idx;
      bit            to;
      logic [AW-2:0] wa;
      logic [15:0]   d[2];
      int            wt[2];
      logic [15:0]   m;
      d[0] = d0; d[1] = d1;
      wt[0] = w0; wt[1] = w1;
      q.delete();
      idx = 0;
      s = base(1'b1, a, wd, w, io, bt);
      s.idx = idx++;
      q.push_back(s);
      nb = (!bt && a[0]) ? 2 : 1;
      wa = a[AW-1:1];
      to = 1'b0;
      for (int b = 0; b < nb; b++) begin
         n = (wt[b] >= TMO) ? TMO : wt[b] + 1;
         for (int k = 0; k < n; k++) begin
            s = base(drop ? 1'($urandom) : 1'b1, a, wd, w, io, bt);
            s.cyc  = 1'b1;
            s.busy = 1'b1;
            s.adr  = (b == 1) ? wa + 1'b1 : wa;
            if (nb == 2) begin
               s.sel = (b == 0) ? 2'b10 : 2'b01;
               s.dat = (b == 0) ? {wd[7:0], 8'h00} : {8'h00, wd[15:8]};
            end else if (bt) begin
               s.sel = a[0] ? 2'b10 : 2'b01;
               s.dat = a[0] ? {wd[7:0], 8'h00} : {8'h00, wd[7:0]};
            end else begin
               s.sel = 2'b11;
               s.dat = wd;
            end
            s.ack = (k == n - 1) && (wt[b] < TMO);
            if (s.ack) s.di = d[b];
            s.idx = idx++;
            q.push_back(s);
         end
         if (wt[b] >= TMO) begin
            to = 1'b1;
            break;
         end
      end
      if (to)           m = 16'hFFFF;
      else if (w)       m = 16'h0000;
      else if (nb == 2) m = {d[1][7:0], d[0][15:8]};
      else if (bt)      m = {8'h00, a[0] ? d[0][15:8] : d[0][7:0]};
      else              m = d[0];
      s = base(drop ? 1'($urandom) : 1'b1, a, wd, w, io, bt);
      s.rdy  = 1'b1;
      s.err  = to;
      s.mem  = m;
      s.busy = 1'b1;
      s.idx  = idx++;
      q.push_back(s);
   endtask

   task automatic gap(input int n, input bit stray);
      step_t s;
      for (int i = 0; i < n; i++) begin
         s = base(1'b0, 20'($urandom), 16'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
         s.ack = stray ? 1'($urandom) : 1'b0;
         s.idx = -1;
         q.push_back(s);
      end
   endtask

   task automatic run();
      foreach (q[i]) begin
         @(posedge clk);
         #1;
         rst       = q[i].rst_n;
         req       = q[i].req;
         addr      = q[i].addr;
         wr_data   = q[i].wd;
         we        = q[i].we;
         m_io      = q[i].io;
         byteop    = q[i].bt;
         bus_ack   = q[i].ack;
         bus_dat_i = q[i].di;
         exp       = q[i];
         exp_on    = 1'b1;
      end
   endtask

   task automatic clr_obs();
      o_adr.delete();
      o_sel.delete();
      o_dat.delete();
      o_mem = 16'h0;
      o_err = 1'b0;
      o_lat = -1;
      o_rdy = 0;
   endtask

   // Compare DUT outputs against the timeline every cycle.
   always @(negedge clk) begin
      if (exp_on) begin
         chk("cyc", bus_cyc, exp.cyc);
         chk("stb", bus_stb, exp.cyc);
         chk("busy", busy, exp.busy);
         chk("mem_rdy", mem_rdy, exp.rdy);
         chk("bus_err", bus_err, exp.err);
         if (exp.cyc) begin
            chk("adr", bus_adr, exp.adr);
            chk("sel", bus_sel, exp.sel);
            chk("we", bus_we, exp.we);
            chk("tga", bus_tga, exp.io);
            if (exp.we)
               chk("dat_o", bus_dat_o & {{8{exp.sel[1]}}, {8{exp.sel[0]}}},
                   exp.dat & {{8{exp.sel[1]}}, {8{exp.sel[0]}}});
         end
         if (exp.chk_mem) begin
            chk("rst_outs", {bus_we, bus_tga, bus_sel, bus_dat_o}, 32'h0);
            chk("rst_adr", bus_adr, 32'h0);
         end
         if (exp.rdy || exp.chk_mem)
            chk("memout", memout, exp.mem);
         if (bus_stb && bus_ack) begin
            o_adr.push_back(bus_adr);
            o_sel.push_back(bus_sel);
            o_dat.push_back(bus_dat_o);
         end
         if (mem_rdy) begin
            o_mem = memout;
            o_err = bus_err;
            o_lat = exp.idx;
            o_rdy++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      step_t s;
      logic [AW-1:0] a;
      rst = 1'b0; req = 1'b0; addr = '0; wr_data = '0;
      we = 1'b0; m_io = 1'b0; byteop = 1'b0;
      bus_ack = 1'b0; bus_dat_i = '0;
      clr_obs();

      // Reset state
      q.delete();
      for (int i = 0; i < 3; i++) begin
         s = base(1'b0, '0, '0, 0, 0, 0);
         s.rst_n   = 1'b0;
         s.chk_mem = 1'b1;
         s.ack     = 1'($urandom);
         q.push_back(s);
      end
      run();

      // Aligned word read, two wait states
      clr_obs();
      build(20'h01234, 16'h0, 0, 0, 0, 2, 0, 16'hBEEF, 16'h0, 0);
      gap(2, 1'b1);
      run();
      chk("d1_adr", o_adr[0], 19'h0091A);
      chk("d1_sel", o_sel[0], 2'b11);
      chk("d1_mem", o_mem, 16'hBEEF);
      chk("d1_rdy_cnt", o_rdy, 1);
      chk("d1_lat", o_lat, 4);

      // Odd word write, split into two byte cycles
      clr_obs();
      build(20'h00101, 16'hA55A, 1, 0, 0, 0, 0, 16'h0, 16'h0, 0);
      gap(2, 1'b0);
      run();
      chk("d2_beats", o_adr.size(), 2);
      chk("d2_adr0", o_adr[0], 19'h00080);
      chk("d2_sel0", o_sel[0], 2'b10);
      chk("d2_hi0", o_dat[0][15:8], 8'h5A);
      chk("d2_adr1", o_adr[1], 19'h00081);
      chk("d2_sel1", o_sel[1], 2'b01);
      chk("d2_lo1", o_dat[1][7:0], 8'hA5);
      chk("d2_rdy_cnt", o_rdy, 1);
      chk("d2_lat", o_lat, 3);

      // Odd word read wrapping the word address
      clr_obs();
      build(20'hFFFFF, 16'h0, 0, 0, 0, 0, 1, 16'h12AB, 16'hCD34, 0);
      gap(1, 1'b0);
      run();
      chk("d3_adr0", o_adr[0], 19'h7FFFF);
      chk("d3_adr1", o_adr[1], 19'h00000);
      chk("d3_mem", o_mem, 16'h3412);

      // Byte read, upper lane, zero wait
      clr_obs();
      build(20'h00003, 16'h0, 0, 1, 1, 0, 0, 16'hC35A, 16'h0, 0);
      gap(1, 1'b0);
      run();
      chk("d4_sel", o_sel[0], 2'b10);
      chk("d4_mem", o_mem, 16'h00C3);
      chk("d4_lat", o_lat, 2);

      // Timeout abort followed by stray acks
      clr_obs();
      build(20'h00200, 16'h0, 0, 0, 0, 9, 0, 16'h1111, 16'h0, 0);
      gap(3, 1'b1);
      run();
      chk("d5_err", o_err, 1'b1);
      chk("d5_mem", o_mem, 16'hFFFF);
      chk("d5_lat", o_lat, TMO + 1);
      chk("d5_rdy_cnt", o_rdy, 1);

      // Reset during the second split cycle, then a fresh request
      clr_obs();
      build(20'h00101, 16'h0, 0, 0, 0, 0, 9, 16'h7777, 16'h0, 0);
      while (q.size() > 3) void'(q.pop_back());
      q[2].rst_n = 1'b0;
      s = base(1'b0, '0, '0, 0, 0, 0);
      s.chk_mem = 1'b1;
      q.push_back(s);
      run();
      chk("d6_no_rdy", o_rdy, 0);
      build(20'h00040, 16'h0, 0, 0, 0, 0, 0, 16'h5EED, 16'h0, 0);
      gap(1, 1'b0);
      run();
      chk("d6_fresh_mem", o_mem, 16'h5EED);
      chk("d6_fresh_lat", o_lat, 2);

      // Randomized requests
      for (int t = 0; t < 300; t++) begin
         a = 20'($urandom);
         case ($urandom_range(0, 7))
            0: a = 20'hFFFFF;
            1: a = 20'hFFFFE;
            default: ;
         endcase
         build(a, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 5), $urandom_range(0, 5),
               16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
         gap($urandom_range(0, 2), 1'($urandom));
         run();
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
